// File: rtl/proj_frame_sched_if.sv
// Handshake and pose bus between the frame sequencer (slave) and its surroundings (master).
interface proj_frame_sched_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned TW = 16
);
  logic            vsync_pulse;
  logic            enable;
  logic [2:0]      rot_en;
  logic [2:0]      rot_neg;
  logic [3*TW-1:0] trans_in;
  logic            proj_done;
  logic            raster_done;
  logic [AW-1:0]   alpha;
  logic [AW-1:0]   beta;
  logic [AW-1:0]   gamma;
  logic [TW-1:0]   x_translate;
  logic [TW-1:0]   y_translate;
  logic [TW-1:0]   z_translate;
  logic            proj_start;
  logic            raster_start;
  logic            frame_done;
  logic            busy;
  logic [7:0]      overrun_cnt;
  logic            wdog_err;

  modport master (
    output vsync_pulse, enable, rot_en, rot_neg, trans_in, proj_done, raster_done,
    input  alpha, beta, gamma, x_translate, y_translate, z_translate,
           proj_start, raster_start, frame_done, busy, overrun_cnt, wdog_err
  );

  modport slave (
    input  vsync_pulse, enable, rot_en, rot_neg, trans_in, proj_done, raster_done,
    output alpha, beta, gamma, x_translate, y_translate, z_translate,
           proj_start, raster_start, frame_done, busy, overrun_cnt, wdog_err
  );
endinterface

// File: rtl/proj_frame_sched.sv
// Per-frame projection sequencer: latches pose on vsync, handshakes projector then rasterizer.
// Optional wait-state watchdog enabled by defining PROJ_WATCHDOG_EN.
module proj_frame_sched #(
  parameter int unsigned WIIA       = 4,
  parameter int unsigned WIFA       = 8,
  parameter int unsigned WI         = 8,
  parameter int unsigned WF         = 8,
  parameter int unsigned ANGLE_WRAP = 1608,
  parameter int unsigned ROT_STEP   = 4
`ifdef PROJ_WATCHDOG_EN
  , parameter int unsigned WDOG_CYCLES = 1048575
`endif
) (
  input logic               Clk,
  input logic               Reset,
  proj_frame_sched_if.slave bus
);
  localparam int unsigned AW = WIIA + WIFA;
  localparam int unsigned TW = WI + WF;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_PROJ, S_RELEASE, S_RASTER, S_DONE
  } state_t;

  state_t state;

  // One rotation step with wrap into [0, ANGLE_WRAP)
  function automatic logic [AW-1:0] step_angle(input logic [AW-1:0] a, input logic neg);
    logic [AW:0] s;
    if (!neg) begin
      s = {1'b0, a} + (AW+1)'(ROT_STEP);
      if (s >= (AW+1)'(ANGLE_WRAP)) s = s - (AW+1)'(ANGLE_WRAP);
    end else if (a < AW'(ROT_STEP)) begin
      s = {1'b0, a} + (AW+1)'(ANGLE_WRAP) - (AW+1)'(ROT_STEP);
    end else begin
      s = {1'b0, a} - (AW+1)'(ROT_STEP);
    end
    return s[AW-1:0];
  endfunction

`ifdef PROJ_WATCHDOG_EN
  logic [19:0] wdog_cnt;
  logic [19:0] wdog_cnt_eff;
  state_t      state_prev;
  logic        in_wait;
  logic        wdog_trip;

  // Count resets on entry to a new state, so each wait state gets its own budget
  assign in_wait      = (state == S_PROJ) || (state == S_RELEASE) || (state == S_RASTER);
  assign wdog_cnt_eff = (state != state_prev) ? 20'd0 : wdog_cnt;
  assign wdog_trip    = in_wait && (wdog_cnt_eff == 20'(WDOG_CYCLES));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_prev <= S_IDLE;
      wdog_cnt   <= 20'd0;
    end else begin
      state_prev <= state;
      wdog_cnt   <= in_wait ? wdog_cnt_eff + 20'd1 : 20'd0;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= S_IDLE;
      bus.alpha       <= '0;
      bus.beta        <= '0;
      bus.gamma       <= '0;
      bus.x_translate <= '0;
      bus.y_translate <= '0;
      bus.z_translate <= '0;
      bus.proj_start  <= 1'b0;
      bus.raster_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun_cnt <= 8'd0;
      bus.wdog_err    <= 1'b0;
    end else begin
      bus.raster_start <= 1'b0;
      bus.frame_done   <= 1'b0;

      // Ticks arriving mid-frame are dropped and counted
      if ((state != S_IDLE) && bus.vsync_pulse && (bus.overrun_cnt != 8'hFF))
        bus.overrun_cnt <= bus.overrun_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (bus.vsync_pulse && bus.enable) begin
            state    <= S_LATCH;
            bus.busy <= 1'b1;
          end
        end
        S_LATCH: begin
          if (bus.rot_en[0]) bus.alpha <= step_angle(bus.alpha, bus.rot_neg[0]);
          if (bus.rot_en[1]) bus.beta  <= step_angle(bus.beta,  bus.rot_neg[1]);
          if (bus.rot_en[2]) bus.gamma <= step_angle(bus.gamma, bus.rot_neg[2]);
          bus.x_translate <= bus.trans_in[TW-1:0];
          bus.y_translate <= bus.trans_in[2*TW-1:TW];
          bus.z_translate <= bus.trans_in[3*TW-1:2*TW];
          bus.proj_start  <= 1'b1;
          state           <= S_PROJ;
        end
        S_PROJ: begin
          if (bus.proj_done) begin
            bus.proj_start <= 1'b0;
            state          <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.proj_done) begin
            bus.raster_start <= 1'b1;
            state            <= S_RASTER;
          end
        end
        S_RASTER: begin
          if (bus.raster_done) begin
            bus.frame_done <= 1'b1;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef PROJ_WATCHDOG_EN
      if (wdog_trip) begin
        bus.proj_start   <= 1'b0;
        bus.raster_start <= 1'b0;
        bus.frame_done   <= 1'b1;
        bus.wdog_err     <= 1'b1;
        state            <= S_DONE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_proj_frame_sched.sv
// Self-checking bench for proj_frame_sched: vector table, corner sequences, randomized frames vs a modular-arithmetic model.
module tb_proj_frame_sched;
  localparam int unsigned AW   = 12;
  localparam int unsigned TW   = 16;
  localparam int          WRAP = 1608;
  localparam int          STEP = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  proj_frame_sched_if #(.AW(AW), .TW(TW)) bus ();
  proj_frame_sched dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int rs_cnt = 0;
  int fd_cnt = 0;
  int rs0, fd0;

  int m_ang[3];
  int m_tr[3];
  int m_ovr;

  typedef struct {
    logic [2:0]  en;
    logic [2:0]  neg;
    logic [15:0] tx, ty, tz;
    int          pd, rd;
    int          ea, eb, eg;
  } vec_t;
  vec_t tbl[7];

  always @(negedge Clk) begin
    if (bus.raster_start) rs_cnt++;
    if (bus.frame_done)   fd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic int ref_angle(input int a, input bit neg);
    return neg ? (a - STEP + WRAP) % WRAP : (a + STEP) % WRAP;
  endfunction

  function automatic bit sig(input int sel);
    case (sel)
      0:       return !bus.proj_start;
      1:       return bus.raster_start;
      default: return bus.frame_done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    for (int i = 0; i < 300; i++) begin
      if (sig(sel)) return;
      step();
    end
    n_chk++;
    $display("FAIL %s: got timeout, expected event within 300 cycles", name);
  endtask

  task automatic check_pose(input string tag);
    chk({tag, "_alpha"}, 32'(bus.alpha), 32'(m_ang[0]));
    chk({tag, "_beta"},  32'(bus.beta),  32'(m_ang[1]));
    chk({tag, "_gamma"}, 32'(bus.gamma), 32'(m_ang[2]));
    chk({tag, "_x"}, 32'(bus.x_translate), 32'(m_tr[0]));
    chk({tag, "_y"}, 32'(bus.y_translate), 32'(m_tr[1]));
    chk({tag, "_z"}, 32'(bus.z_translate), 32'(m_tr[2]));
  endtask

  // Pulse vsync in IDLE and land on the first PROJ cycle (N+2)
  task automatic start_frame(input logic [2:0] en, input logic [2:0] neg,
                             input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] tz);
    rs0 = rs_cnt;
    fd0 = fd_cnt;
    bus.rot_en      = en;
    bus.rot_neg     = neg;
    bus.trans_in    = {tz, ty, tx};
    bus.enable      = 1'b1;
    bus.vsync_pulse = 1'b1;
    step();
    bus.vsync_pulse = 1'b0;
    chk("latch_busy", 32'(bus.busy), 32'd1);
    step();
    chk("proj_start_latency", 32'(bus.proj_start), 32'd1);
    for (int i = 0; i < 3; i++)
      if (en[i]) m_ang[i] = ref_angle(m_ang[i], neg[i]);
    m_tr[0] = int'(tx);
    m_tr[1] = int'(ty);
    m_tr[2] = int'(tz);
    check_pose("pose");
  endtask

  task automatic finish_frame(input int pd, input int rd);
    repeat (pd) step();
    bus.proj_done = 1'b1;
    wait_for(0, "proj_start_drop");
    bus.proj_done = 1'b0;
    wait_for(1, "raster_start");
    repeat (rd) step();
    bus.raster_done = 1'b1;
    wait_for(2, "frame_done");
    bus.raster_done = 1'b0;
    step();
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("raster_start_pulses", 32'(rs_cnt - rs0), 32'd1);
    chk("frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
  endtask

  task automatic vsync_blip();
    bus.vsync_pulse = 1'b1;
    step();
    bus.vsync_pulse = 1'b0;
    step();
  endtask

  initial begin
    tbl[0] = '{3'b001, 3'b000, 16'h0100, 16'h0200, 16'h0300, 10, 5,    4,    0, 0};
    tbl[1] = '{3'b001, 3'b001, 16'h1234, 16'h5678, 16'h9ABC,  0, 0,    0,    0, 0};
    tbl[2] = '{3'b010, 3'b010, 16'hFFFF, 16'h0000, 16'h8000,  2, 1,    0, 1604, 0};
    tbl[3] = '{3'b110, 3'b000, 16'h0001, 16'h0002, 16'h0003,  1, 3,    0,    0, 4};
    tbl[4] = '{3'b111, 3'b101, 16'hAAAA, 16'h5555, 16'h0F0F,  3, 0, 1604,    4, 0};
    tbl[5] = '{3'b001, 3'b000, 16'h00FF, 16'hFF00, 16'h7FFF,  0, 2,    0,    4, 0};
    tbl[6] = '{3'b000, 3'b111, 16'h0042, 16'h0043, 16'h0044,  4, 4,    0,    4, 0};

    Reset           = 1'b1;
    bus.vsync_pulse = 1'b0;
    bus.enable      = 1'b0;
    bus.rot_en      = '0;
    bus.rot_neg     = '0;
    bus.trans_in    = '0;
    bus.proj_done   = 1'b0;
    bus.raster_done = 1'b0;
    m_ang = '{0, 0, 0};
    m_tr  = '{0, 0, 0};
    m_ovr = 0;
    repeat (3) step();
    check_pose("reset");
    chk("reset_proj_start", 32'(bus.proj_start), 32'd0);
    chk("reset_raster_start", 32'(bus.raster_start), 32'd0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_overrun", 32'(bus.overrun_cnt), 32'd0);
    chk("reset_wdog", 32'(bus.wdog_err), 32'd0);
    Reset = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      start_frame(tbl[v].en, tbl[v].neg, tbl[v].tx, tbl[v].ty, tbl[v].tz);
      finish_frame(tbl[v].pd, tbl[v].rd);
      chk("tbl_alpha", 32'(bus.alpha), 32'(tbl[v].ea));
      chk("tbl_beta",  32'(bus.beta),  32'(tbl[v].eb));
      chk("tbl_gamma", 32'(bus.gamma), 32'(tbl[v].eg));
    end

    // vsync with enable low in IDLE is ignored
    bus.enable      = 1'b0;
    bus.vsync_pulse = 1'b1;
    step();
    bus.vsync_pulse = 1'b0;
    step();
    chk("disabled_busy", 32'(bus.busy), 32'd0);
    chk("disabled_overrun", 32'(bus.overrun_cnt), 32'(m_ovr));

    // Overruns in PROJ, translate change mid-frame, proj_done held, vsync in DONE
    start_frame(3'b000, 3'b000, 16'h1111, 16'h2222, 16'h3333);
    bus.trans_in = {16'hDEAD, 16'hBEEF, 16'hCAFE};
    bus.enable   = 1'b0;
    repeat (3) vsync_blip();
    m_ovr += 3;
    chk("ovr3", 32'(bus.overrun_cnt), 32'(m_ovr));
    check_pose("midframe");
    bus.proj_done = 1'b1;
    step();
    chk("release_proj_start", 32'(bus.proj_start), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_no_raster_start", 32'(bus.raster_start), 32'd0);
    end
    bus.proj_done = 1'b0;
    step();
    chk("raster_start_after_release", 32'(bus.raster_start), 32'd1);
    bus.raster_done = 1'b1;
    step();
    chk("done_pulse", 32'(bus.frame_done), 32'd1);
    bus.raster_done = 1'b0;
    bus.vsync_pulse = 1'b1;
    step();
    bus.vsync_pulse = 1'b0;
    m_ovr += 1;
    chk("done_vsync_counted", 32'(bus.overrun_cnt), 32'(m_ovr));
    chk("done_vsync_no_start", 32'(bus.busy), 32'd0);
    step();
    chk("one_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check_pose("after_midframe");

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      logic [2:0]  r_en, r_neg;
      logic [15:0] rx, ry, rz;
      int          nv;
      r_en  = 3'($urandom);
      r_neg = 3'($urandom);
      rx    = 16'($urandom);
      ry    = 16'($urandom);
      rz    = 16'($urandom);
      start_frame(r_en, r_neg, rx, ry, rz);
      nv = $urandom_range(0, 2);
      for (int k = 0; k < nv; k++) vsync_blip();
      m_ovr += nv;
      finish_frame($urandom_range(0, 6), $urandom_range(0, 6));
      chk("rand_overrun", 32'(bus.overrun_cnt), 32'(m_ovr));
      check_pose("rand_hold");
    end

    // Saturation of the overrun counter
    start_frame(3'b001, 3'b000, 16'h0001, 16'h0001, 16'h0001);
    for (int k = 0; k < 300; k++) vsync_blip();
    m_ovr = (m_ovr + 300 > 255) ? 255 : m_ovr + 300;
    chk("ovr_saturate", 32'(bus.overrun_cnt), 32'(m_ovr));
    finish_frame(1, 1);

    // Reset in the middle of PROJ
    start_frame(3'b111, 3'b000, 16'h0F00, 16'h00F0, 16'h000F);
    fd0 = fd_cnt;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_ang = '{0, 0, 0};
    m_tr  = '{0, 0, 0};
    chk("rst_proj_start", 32'(bus.proj_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
    check_pose("rst_pose");
    step();
    chk("rst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    chk("final_wdog", 32'(bus.wdog_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
